// File: rtl/btn_gesture.sv
// Press-gesture classifier: turns debounced press/level into short, double and
// long press pulses and steps the LED mode register accordingly.
module btn_gesture #(
  parameter int LONG_CYC = 8,
  parameter int GAP_CYC  = 5,
  parameter int MODES    = 4,
  localparam int MODE_W  = $clog2(MODES)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              btn_level,
  input  logic              btn_press,
  output logic              short_press,
  output logic              double_press,
  output logic              long_press,
  output logic [MODE_W-1:0] led_mode,
  output logic              busy,
  output logic [2:0]        fsm_state
);

  localparam int T_MAX   = (LONG_CYC > GAP_CYC) ? LONG_CYC : GAP_CYC;
  localparam int TIMER_W = $clog2(T_MAX);

  localparam logic [TIMER_W-1:0] LONG_LAST = TIMER_W'(LONG_CYC - 1);
  localparam logic [TIMER_W-1:0] GAP_LAST  = TIMER_W'(GAP_CYC - 1);
  localparam logic [MODE_W-1:0]  MODE_LAST = MODE_W'(MODES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    HELD1     = 3'd1,
    WAIT2     = 3'd2,
    HELD2     = 3'd3,
    LONG_WAIT = 3'd4
  } state_t;

  state_t              state, state_next;
  logic [TIMER_W-1:0]  timer, timer_next;
  logic                short_next, double_next, long_next;
  logic [MODE_W-1:0]   mode_next;

  assign fsm_state = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      timer        <= '0;
      short_press  <= 1'b0;
      double_press <= 1'b0;
      long_press   <= 1'b0;
      led_mode     <= '0;
      busy         <= 1'b0;
    end else begin
      state        <= state_next;
      timer        <= timer_next;
      short_press  <= short_next;
      double_press <= double_next;
      long_press   <= long_next;
      led_mode     <= mode_next;
      busy         <= (state_next != IDLE);
    end
  end

  always_comb begin
    state_next  = state;
    timer_next  = timer;
    short_next  = 1'b0;
    double_next = 1'b0;
    long_next   = 1'b0;
    case (state)
      IDLE: begin
        if (btn_press) begin
          state_next = HELD1;
          timer_next = '0;
        end
      end
      HELD1: begin
        // Release is tested first so a release on the last hold cycle stays short.
        if (!btn_level) begin
          state_next = WAIT2;
          timer_next = '0;
        end else if (timer == LONG_LAST) begin
          long_next  = 1'b1;
          state_next = LONG_WAIT;
        end else begin
          timer_next = timer + TIMER_W'(1);
        end
      end
      WAIT2: begin
        if (btn_press) begin
          double_next = 1'b1;
          state_next  = HELD2;
        end else if (timer == GAP_LAST) begin
          short_next = 1'b1;
          state_next = IDLE;
        end else begin
          timer_next = timer + TIMER_W'(1);
        end
      end
      HELD2, LONG_WAIT: begin
        if (!btn_level) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        timer_next = '0;
      end
    endcase
  end

  // Explicit compare-and-wrap keeps non-power-of-two mode counts correct.
  always_comb begin
    mode_next = led_mode;
    if (short_next) begin
      mode_next = (led_mode == MODE_LAST) ? '0 : led_mode + MODE_W'(1);
    end else if (double_next) begin
      mode_next = (led_mode == '0) ? MODE_LAST : led_mode - MODE_W'(1);
    end else if (long_next) begin
      mode_next = '0;
    end
  end

endmodule

// File: tb/tb_btn_gesture.sv
// Bench for btn_gesture: directed gesture scenarios plus random gestures, all
// checked cycle by cycle against a timestamp-based gesture model.
module tb_btn_gesture;

  localparam int LONG_CYC = 8;
  localparam int GAP_CYC  = 5;
  localparam int MODES    = 4;
  localparam int MODE_W   = $clog2(MODES);
  localparam int EV_W     = 2 + MODE_W;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              btn_level = 1'b0;
  logic              btn_press = 1'b0;
  logic              short_press, double_press, long_press, busy;
  logic [MODE_W-1:0] led_mode;
  logic [2:0]        fsm_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [EV_W-1:0] exp_q[$];

  // Reference model: gesture tracked by accept/release timestamps.
  bit m_active = 1'b0, m_tail = 1'b0;
  bit m_short = 1'b0, m_double = 1'b0, m_long = 1'b0;
  int m_cyc = 0, m_t_acc = 0, m_t_rel = -1, m_mode = 0;
  bit chk_en = 1'b0;
  int cnt_short = 0, cnt_double = 0, cnt_long = 0;

  always #5 clk = ~clk;

  btn_gesture #(.LONG_CYC(LONG_CYC), .GAP_CYC(GAP_CYC), .MODES(MODES)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .btn_level    (btn_level),
    .btn_press    (btn_press),
    .short_press  (short_press),
    .double_press (double_press),
    .long_press   (long_press),
    .led_mode     (led_mode),
    .busy         (busy),
    .fsm_state    (fsm_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic level, input logic press);
    btn_level = level;
    btn_press = press;
    @(negedge clk);
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_active = 1'b0; m_tail = 1'b0; m_t_rel = -1; m_mode = 0;
        m_short = 1'b0; m_double = 1'b0; m_long = 1'b0;
        exp_q.delete();
      end else begin
        m_short = 1'b0; m_double = 1'b0; m_long = 1'b0;
        if (!m_active) begin
          if (btn_press) begin
            m_active = 1'b1; m_tail = 1'b0; m_t_acc = m_cyc; m_t_rel = -1;
          end
        end else if (m_tail) begin
          if (!btn_level) m_active = 1'b0;
        end else if (m_t_rel < 0) begin
          if (!btn_level) m_t_rel = m_cyc;
          else if (m_cyc - m_t_acc == LONG_CYC) begin
            m_long = 1'b1; m_mode = 0; m_tail = 1'b1;
          end
        end else begin
          if (btn_press) begin
            m_double = 1'b1; m_mode = (m_mode + MODES - 1) % MODES; m_tail = 1'b1;
          end else if (m_cyc - m_t_rel == GAP_CYC) begin
            m_short = 1'b1; m_mode = (m_mode + 1) % MODES; m_active = 1'b0;
          end
        end
        if (m_short)  exp_q.push_back({2'd1, MODE_W'(m_mode)});
        if (m_double) exp_q.push_back({2'd2, MODE_W'(m_mode)});
        if (m_long)   exp_q.push_back({2'd3, MODE_W'(m_mode)});
        m_cyc++;
      end
    end
  end

  initial begin
    logic [EV_W-1:0] e;
    logic [1:0] code;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("cycle", 32'({short_press, double_press, long_press, busy, led_mode}),
              32'({m_short, m_double, m_long, m_active, MODE_W'(m_mode)}));
        if (short_press)  cnt_short++;
        if (double_press) cnt_double++;
        if (long_press)   cnt_long++;
        if (short_press || double_press || long_press) begin
          code = short_press ? 2'd1 : (double_press ? 2'd2 : 2'd3);
          if (exp_q.size() == 0) begin
            check("evt_unexpected", 32'(code), 32'(0));
          end else begin
            e = exp_q.pop_front();
            check("evt", 32'({code, led_mode}), 32'(e));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic short_gesture(input int hold, output int lat);
    lat = -1;
    drive(1'b1, 1'b1);
    repeat (hold - 1) drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    for (int j = 1; j <= GAP_CYC + 3; j++) begin
      drive(1'b0, 1'b0);
      if (short_press && lat < 0) lat = j;
    end
  endtask

  initial begin
    int lat, nl, ev0, s0;
    int exp_modes[4] = '{1, 2, 3, 0};

    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out", 32'({short_press, double_press, long_press, busy, led_mode}), 32'(0));
    reset_n = 1'b1;
    chk_en = 1'b1;
    drive(1'b0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      short_gesture(3, lat);
      check("short_lat", 32'(lat), 32'(GAP_CYC));
      check("short_mode", 32'(led_mode), 32'(exp_modes[i]));
    end
    short_gesture(3, lat);
    short_gesture(3, lat);
    check("pre_long_mode", 32'(led_mode), 32'(2));

    lat = -1; nl = 0;
    drive(1'b1, 1'b1);
    for (int j = 1; j < 20; j++) begin
      drive(1'b1, 1'b0);
      if (long_press) begin
        nl++;
        if (lat < 0) lat = j;
      end
    end
    check("long_lat", 32'(lat), 32'(LONG_CYC));
    check("long_cnt", 32'(nl), 32'(1));
    check("long_mode", 32'(led_mode), 32'(0));
    ev0 = cnt_short + cnt_double + cnt_long;
    repeat (8) drive(1'b0, 1'b0);
    check("long_release_quiet", 32'(cnt_short + cnt_double + cnt_long - ev0), 32'(0));
    check("long_busy", 32'(busy), 32'(0));

    s0 = cnt_short;
    drive(1'b1, 1'b1); drive(1'b1, 1'b0); drive(1'b1, 1'b0);
    drive(1'b0, 1'b0); drive(1'b0, 1'b0);
    drive(1'b1, 1'b1);
    check("dbl_pulse", 32'(double_press), 32'(1));
    check("dbl_mode", 32'(led_mode), 32'(3));
    drive(1'b1, 1'b0); drive(1'b1, 1'b0);
    repeat (8) drive(1'b0, 1'b0);
    check("dbl_no_short", 32'(cnt_short - s0), 32'(0));

    s0 = cnt_short;
    drive(1'b1, 1'b1); drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    repeat (4) drive(1'b0, 1'b0);
    drive(1'b1, 1'b1);
    check("gap_edge_dbl", 32'(double_press), 32'(1));
    check("gap_edge_mode", 32'(led_mode), 32'(2));
    repeat (8) drive(1'b0, 1'b0);
    check("gap_edge_no_short", 32'(cnt_short - s0), 32'(0));

    nl = cnt_long; lat = -1;
    drive(1'b1, 1'b1);
    repeat (LONG_CYC - 1) drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    for (int j = 1; j <= GAP_CYC + 3; j++) begin
      drive(1'b0, 1'b0);
      if (short_press && lat < 0) lat = j;
    end
    check("hold_edge_no_long", 32'(cnt_long - nl), 32'(0));
    check("hold_edge_short_lat", 32'(lat), 32'(GAP_CYC));
    check("hold_edge_mode", 32'(led_mode), 32'(3));

    drive(1'b1, 1'b1);
    repeat (3) drive(1'b1, 1'b0);
    #2 reset_n = 1'b0;
    #1 check("rst_async", 32'({short_press, double_press, long_press, busy, led_mode}), 32'(0));
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    ev0 = cnt_short + cnt_double + cnt_long;
    repeat (3) drive(1'b1, 1'b0);
    repeat (10) drive(1'b0, 1'b0);
    check("rst_no_event", 32'(cnt_short + cnt_double + cnt_long - ev0), 32'(0));
    check("rst_mode", 32'(led_mode), 32'(0));

    ev0 = cnt_short + cnt_double + cnt_long; s0 = cnt_short;
    drive(1'b1, 1'b1); drive(1'b1, 1'b1); drive(1'b1, 1'b0); drive(1'b1, 1'b1);
    check("ign_h1_busy", 32'(busy), 32'(1));
    drive(1'b0, 1'b0);
    repeat (8) drive(1'b0, 1'b0);
    check("ign_h1_short", 32'(cnt_short - s0), 32'(1));
    check("ign_h1_total", 32'(cnt_short + cnt_double + cnt_long - ev0), 32'(1));

    ev0 = cnt_short + cnt_double + cnt_long;
    drive(1'b1, 1'b1); drive(1'b0, 1'b0); drive(1'b1, 1'b1);
    repeat (3) drive(1'b1, 1'b1);
    check("ign_h2_busy", 32'(busy), 32'(1));
    repeat (8) drive(1'b0, 1'b0);
    check("ign_h2_total", 32'(cnt_short + cnt_double + cnt_long - ev0), 32'(1));
    check("ign_h2_mode", 32'(led_mode), 32'(0));

    ev0 = cnt_short + cnt_double + cnt_long;
    drive(1'b1, 1'b1);
    repeat (LONG_CYC + 1) drive(1'b1, 1'b0);
    repeat (3) drive(1'b1, 1'b1);
    check("ign_lw_busy", 32'(busy), 32'(1));
    repeat (8) drive(1'b0, 1'b0);
    check("ign_lw_total", 32'(cnt_short + cnt_double + cnt_long - ev0), 32'(1));
    check("ign_lw_busy_end", 32'(busy), 32'(0));

    drive(1'b0, 1'b1);
    repeat (8) drive(1'b0, 1'b0);
    check("idle_low_press_mode", 32'(led_mode), 32'(1));

    for (int g = 0; g < 40; g++) begin
      int hold, gap;
      hold = $urandom_range(1, 12);
      gap  = $urandom_range(0, 7);
      drive(1'b1, 1'b1);
      repeat (hold - 1) drive(1'b1, ($urandom_range(0, 5) == 0));
      repeat (gap + 1) drive(1'b0, 1'b0);
      if ($urandom_range(0, 1) == 1) begin
        drive(1'b1, 1'b1);
        repeat ($urandom_range(0, 4)) drive(1'b1, ($urandom_range(0, 3) == 0));
        drive(1'b0, 1'b0);
      end
      repeat ($urandom_range(0, 8)) drive(1'b0, 1'b0);
    end

    repeat (12) drive(1'b0, 1'b0);
    check("exp_q_empty", 32'(exp_q.size()), 32'(0));
    check("final_busy", 32'(busy), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
